p4_router_egress_dequeue_scheduler: RTL

//  Sequences head-pointer lookups on the router queue-state store to drain egress queues.

---
 rtl/p4_router_egress_dequeue_scheduler.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/p4_router_egress_dequeue_scheduler.sv
// Egress dequeue scheduler: round-robin across egress ports, strict priority within a port,
// one head-pointer lookup per buffer word, each lookup response forwarded as a dequeue descriptor.
module p4_router_egress_dequeue_scheduler #(
  parameter int NUM_EGR_PORTS           = 4,
  parameter int NUM_QUEUES_PER_EGR_PORT = 8,
  parameter int MAX_BURST_WORDS         = 16,
  parameter int PTR_WIDTH               = 16,
  localparam int NUM_QUEUES = NUM_EGR_PORTS * NUM_QUEUES_PER_EGR_PORT,
  localparam int QL         = (NUM_QUEUES > 1) ? $clog2(NUM_QUEUES) : 1,
  localparam int PL         = (NUM_EGR_PORTS > 1) ? $clog2(NUM_EGR_PORTS) : 1
) (
  input  logic                     clk,
  input  logic                     sreset,
  input  logic [NUM_QUEUES-1:0]    queue_empty,
  input  logic [NUM_EGR_PORTS-1:0] egr_port_ready,
  output logic                     head_req_valid,
  input  logic                     head_req_ready,
  output logic [QL-1:0]            head_req_qid,
  input  logic                     head_rsp_valid,
  input  logic [PTR_WIDTH-1:0]     head_rsp_data,
  output logic                     head_rsp_ready,
  output logic                     deq_valid,
  output logic [QL-1:0]            deq_qid,
  output logic [PL-1:0]            deq_port,
  output logic [PTR_WIDTH-1:0]     deq_ptr,
  output logic                     deq_last
);

  localparam int Q  = NUM_QUEUES_PER_EGR_PORT;
  localparam int BW = $clog2(MAX_BURST_WORDS + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_RSP
  } state_e;

  state_e               state_q, state_d;
  logic [PL-1:0]        rr_ptr_q, rr_ptr_d;
  logic [PL-1:0]        port_q, port_d;
  logic [QL-1:0]        qid_q, qid_d;
  logic [BW-1:0]        burst_cnt_q, burst_cnt_d;
  logic                 deq_valid_q, deq_valid_d;
  logic                 deq_last_q, deq_last_d;
  logic [QL-1:0]        deq_qid_q, deq_qid_d;
  logic [PL-1:0]        deq_port_q, deq_port_d;
  logic [PTR_WIDTH-1:0] deq_ptr_q, deq_ptr_d;

  logic [NUM_EGR_PORTS-1:0] port_elig;
  logic [QL-1:0]            port_first_qid [NUM_EGR_PORTS];
  logic                     grant_found;
  logic [PL-1:0]            grant_port;
  logic [BW-1:0]            burst_inc;
  logic                     burst_more;

  // Per-port eligibility and its highest-priority (lowest-index) non-empty queue.
  always_comb begin
    for (int p = 0; p < NUM_EGR_PORTS; p++) begin
      port_elig[p]      = egr_port_ready[p] && !(&queue_empty[p*Q +: Q]);
      port_first_qid[p] = '0;
      for (int i = Q - 1; i >= 0; i--) begin
        if (!queue_empty[p*Q + i]) port_first_qid[p] = QL'(p*Q + i);
      end
    end
  end

  // Round-robin search starting one past the last granted port.
  always_comb begin
    grant_found = 1'b0;
    grant_port  = '0;
    for (int k = 1; k <= NUM_EGR_PORTS; k++) begin
      int idx;
      idx = (int'(rr_ptr_q) + k) % NUM_EGR_PORTS;
      if (!grant_found && port_elig[idx]) begin
        grant_found = 1'b1;
        grant_port  = PL'(idx);
      end
    end
  end

  assign burst_inc  = burst_cnt_q + BW'(1);
  assign burst_more = (int'(burst_inc) < MAX_BURST_WORDS) && !queue_empty[qid_q]
                      && egr_port_ready[port_q];

  // NOTE: every signal written here gets a default first, so no path leaves one unassigned and infers a latch.
  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    port_d      = port_q;
    qid_d       = qid_q;
    burst_cnt_d = burst_cnt_q;
    deq_valid_d = 1'b0;
    deq_last_d  = 1'b0;
    deq_qid_d   = deq_qid_q;
    deq_port_d  = deq_port_q;
    deq_ptr_d   = deq_ptr_q;
    unique case (state_q)
      S_IDLE: begin
        if (grant_found) begin
          port_d      = grant_port;
          qid_d       = port_first_qid[grant_port];
          rr_ptr_d    = grant_port;
          burst_cnt_d = '0;
          state_d     = S_REQ;
        end
      end
      S_REQ: begin
        if (head_req_ready) state_d = S_RSP;
      end
      S_RSP: begin
        if (head_rsp_valid) begin
          deq_valid_d = 1'b1;
          deq_qid_d   = qid_q;
          deq_port_d  = port_q;
          deq_ptr_d   = head_rsp_data;
          burst_cnt_d = burst_inc;
          if (burst_more) begin
            state_d = S_REQ;
          end else begin
            deq_last_d = 1'b1;
            state_d    = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (sreset) begin
      state_q     <= S_IDLE;
      rr_ptr_q    <= PL'(NUM_EGR_PORTS - 1);
      port_q      <= '0;
      qid_q       <= '0;
      burst_cnt_q <= '0;
      deq_valid_q <= 1'b0;
      deq_last_q  <= 1'b0;
      deq_qid_q   <= '0;
      deq_port_q  <= '0;
      deq_ptr_q   <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      port_q      <= port_d;
      qid_q       <= qid_d;
      burst_cnt_q <= burst_cnt_d;
      deq_valid_q <= deq_valid_d;
      deq_last_q  <= deq_last_d;
      deq_qid_q   <= deq_qid_d;
      deq_port_q  <= deq_port_d;
      deq_ptr_q   <= deq_ptr_d;
    end
  end

  assign head_req_valid = (state_q == S_REQ);
  assign head_req_qid   = qid_q;
  assign head_rsp_ready = 1'b1;
  assign deq_valid      = deq_valid_q;
  assign deq_last       = deq_last_q;
  assign deq_qid        = deq_qid_q;
  assign deq_port       = deq_port_q;
  assign deq_ptr        = deq_ptr_q;

endmodule
